// File: rtl/mmr_initiator.sv
// Purpose : memory-mapped register bus initiator; queues client requests and runs them one at a time on the bus.
// Latency : enable rises 1 cycle after a request is accepted, is held HOLD cycles, and rsp_valid rises HOLD+1 cycles after acceptance.
// Backpr. : req_ready is the registered FIFO not-full flag (low in reset); a response is held stable until rsp_ready.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   req_valid/req_ready             request handshake carrying req_rw, req_addr, req_wdata
//   rsp_valid/rsp_ready             response handshake carrying rsp_rw, rsp_rdata (0 for writes)
//   enable, rw, addr, data          shared bus; data is driven only during write transactions

// Small synchronous FIFO used for the request queue.
// Latency : an entry pushed at edge T is visible on out_dat/out_vld after T.
// Backpr. : in_rdy is registered not-full and ignores a same-cycle pop; low during reset.
module mmr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rdy_q, rdy_d;
    logic          push, pop;

    assign push    = in_vld && rdy_q;
    assign pop     = out_rdy && (count_q != '0);
    assign in_rdy  = rdy_q;
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        rdy_d   = (count_d != (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat;
    end
endmodule

module mmr_initiator #(
    parameter int ABITS = 32,
    parameter int DBITS = 32,
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [ABITS-1:0] req_addr,
    input  logic [DBITS-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_rw,
    output logic [DBITS-1:0] rsp_rdata,
    output logic             enable,
    output logic             rw,
    output logic [ABITS-1:0] addr,
    inout  wire  [DBITS-1:0] data
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef struct packed {
        logic             rw;
        logic [ABITS-1:0] addr;
        logic [DBITS-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    req_t   fifo_in_dat, fifo_out_dat;
    logic   fifo_out_vld, fifo_out_rdy;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic             rw_q, rw_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic             drive_q, drive_d;
    logic             cur_rw_q, cur_rw_d;
    logic [DBITS-1:0] wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_rw_q, rsp_rw_d;
    logic [DBITS-1:0] rsp_rdata_q, rsp_rdata_d;

    assign fifo_in_dat = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
    // The head is only consumed from IDLE, so one transaction is in flight at most.
    assign fifo_out_rdy = (state_q == IDLE);

    mmr_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (req_valid),
        .in_rdy  (req_ready),
        .in_dat  (fifo_in_dat),
        .out_vld (fifo_out_vld),
        .out_rdy (fifo_out_rdy),
        .out_dat (fifo_out_dat)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enable_d    = enable_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        drive_d     = drive_q;
        cur_rw_d    = cur_rw_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (fifo_out_vld) begin
                    // Bus outputs are loaded here so they are live in the first BUS cycle.
                    cur_rw_d = fifo_out_dat.rw;
                    wdata_d  = fifo_out_dat.wdata;
                    cnt_d    = CW'(HOLD - 1);
                    enable_d = 1'b1;
                    rw_d     = fifo_out_dat.rw;
                    addr_d   = fifo_out_dat.addr;
                    drive_d  = fifo_out_dat.rw;
                    state_d  = BUS;
                end
            end
            BUS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Last enabled edge: the responder's read data is valid now.
                    rsp_rdata_d = cur_rw_q ? '0 : data;
                    rsp_rw_d    = cur_rw_q;
                    rsp_valid_d = 1'b1;
                    enable_d    = 1'b0;
                    rw_d        = 1'b0;
                    drive_d     = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            enable_q    <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            drive_q     <= 1'b0;
            cur_rw_q    <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            drive_q     <= drive_d;
            cur_rw_q    <= cur_rw_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign enable    = enable_q;
    assign rw        = rw_q;
    assign addr      = addr_q;
    assign data      = drive_q ? wdata_q : 'z;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rw    = rsp_rw_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/mmr_initiator.md
Name: mmr_initiator

Overview:
- Bus initiator for the shared memory-mapped register bus (enable / rw / addr / tristate data).
- Accepts read/write requests from a local client over a valid/ready interface and queues them in a small FIFO.
- Runs one bus transaction at a time and returns one response per request, in request order, over a second valid/ready interface.
- It is the master-side counterpart that drives existing mmr responders, used by the debug/host bridge and any non-CPU master.

Parameters:
ABITS, 32, bus address width
DBITS, 32, bus data width
DEPTH, 4, request FIFO entries (power of 2, >=2)
HOLD, 1, cycles enable is held per transaction (>=1); read data sampled on the last one

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  client request present
req_ready  output  1  FIFO can accept (not full, not in reset)
req_rw  input  1  1 = write, 0 = read
req_addr  input  ABITS  target address
req_wdata  input  DBITS  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  client takes response
rsp_rw  output  1  rw of the completed request
rsp_rdata  output  DBITS  read data; 0 for writes
enable  output  1  bus strobe
rw  output  1  bus direction, 1 = write
addr  output  ABITS  bus address
data  inout  DBITS  bus data; driven only during write transactions, else high-Z

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empties, FSM goes to IDLE.
  - enable=0, rw=0, addr=0, data=Z, rsp_valid=0, rsp_rw=0, rsp_rdata=0.
  - req_ready=0 while reset is high, then reflects FIFO state.
- Push: on req_valid && req_ready, {rw,addr,wdata} enters the FIFO tail.
- req_ready = !full, registered, not pop-aware. No push when full, even if a pop happens the same cycle.
- No bypass: a request always passes through the FIFO.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into holding register, load hold counter with HOLD-1, go to BUS. Otherwise stay.
  - BUS:
    - Drive enable=1, rw and addr from the holding register, data=wdata if rw=1, else Z.
    - Counter >0: decrement, stay.
    - Counter =0: if read, capture data into rsp_rdata; if write, rsp_rdata<=0. Set rsp_rw, rsp_valid<=1, go to RESP.
  - RESP:
    - enable=0, rw=0, addr holds last value, data=Z.
    - rsp_valid held with rsp_rdata and rsp_rw stable until rsp_ready.
    - On rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE.
- Latency:
  - Request accepted at edge T0 with FSM idle: enable high during cycles T1..T1+HOLD-1.
  - rsp_valid rises at edge T1+HOLD, i.e. HOLD+1 cycles after acceptance.
  - Minimum request-to-request spacing on the bus is HOLD+2 cycles (RESP plus IDLE bubble).
- Capacity: DEPTH queued entries plus 1 in flight, so DEPTH+1 requests are accepted while a response is stalled.
- Writes are applied by the responder on every enabled edge. HOLD>1 rewrites the same value, which is harmless.
- Read of an address with no responder: rsp_rdata is whatever the undriven bus resolves to (X in simulation). Not an error condition; no timeout.
- Reset mid-operation:
  - The transaction is abandoned and enable drops the cycle after reset is sampled.
  - Queued requests are discarded and no response is issued.
- Simultaneous push and pop on the same edge: both take effect and the count is unchanged.
- Pointers wrap modulo DEPTH.

Test Plan:
- Bench setup: HOLD=1, DEPTH=4. Responder A is an mmr at ADDR=0x10 with DEFAULT=0xdeadbeef; responder B is an mmr at ADDR=0x20 with DEFAULT=0.
- Read 0x10 accepted at T0 -> enable=1, rw=0, addr=0x10 in cycle T1 only; rsp_valid at T2 with rsp_rdata=0xdeadbeef, rsp_rw=0.
- Write 0x20 with 0x12345678, then read 0x20 -> write response rsp_rw=1, rsp_rdata=0; data driven only while enable=1; read returns 0x12345678.
- rsp_ready=0 and req_valid held with 8 reads -> exactly 5 accepted, then req_ready=0. Release rsp_ready -> 5 responses in request order, then req_ready returns to 1.
- rsp_ready=0 for 10 cycles after a response -> rsp_valid, rsp_rdata and rsp_rw stable; enable stays 0; no new bus transaction starts.
- Assert reset for 1 cycle while in BUS with 3 requests queued -> enable=0 next cycle; no rsp_valid ever for those requests; req_ready=1 the cycle after reset deasserts.
- HOLD=3: read 0x10 -> enable high for exactly 3 cycles; rsp_valid 4 cycles after acceptance with 0xdeadbeef.
